// File: rtl/keypad_entry_pkg.sv
// Shared key-code encodings and helpers for the keypad path.
// Codes 0x00..0x0F are hex keys; anything with bit 4 set means no key.
package keypad_entry_pkg;

   localparam logic [4:0] KEY_0    = 5'h00;
   localparam logic [4:0] KEY_1    = 5'h01;
   localparam logic [4:0] KEY_2    = 5'h02;
   localparam logic [4:0] KEY_3    = 5'h03;
   localparam logic [4:0] KEY_4    = 5'h04;
   localparam logic [4:0] KEY_5    = 5'h05;
   localparam logic [4:0] KEY_6    = 5'h06;
   localparam logic [4:0] KEY_7    = 5'h07;
   localparam logic [4:0] KEY_8    = 5'h08;
   localparam logic [4:0] KEY_9    = 5'h09;
   localparam logic [4:0] KEY_A    = 5'h0A;
   localparam logic [4:0] KEY_B    = 5'h0B;
   localparam logic [4:0] KEY_C    = 5'h0C;
   localparam logic [4:0] KEY_D    = 5'h0D;
   localparam logic [4:0] KEY_E    = 5'h0E;
   localparam logic [4:0] KEY_F    = 5'h0F;
   localparam logic [4:0] KEY_NONE = 5'h10;

   function automatic logic key_is_hex(input logic [4:0] k);
      return !k[4];
   endfunction

   function automatic logic key_is_digit(input logic [4:0] k);
      return !k[4] && (k[3:0] <= 4'hD);
   endfunction

   function automatic logic [3:0] key_to_nibble(input logic [4:0] k);
      return k[3:0];
   endfunction

endpackage

// File: rtl/keypad_entry_debounce.sv
// Key-code debouncer: a code must be seen STABLE_CYCLES times in a row
// before it becomes the stable key; each change to a real key is a press.
module key_debounce
   import keypad_entry_pkg::*;
#(
   parameter int STABLE_CYCLES = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] key_in,
   output logic [4:0] stable,
   output logic       press,
   output logic [4:0] press_key
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   logic [4:0]    key;
   logic [4:0]    cand;
   logic [CW-1:0] cnt;

   assign key = key_is_hex(key_in) ? key_in : KEY_NONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand      <= KEY_NONE;
         cnt       <= '0;
         stable    <= KEY_NONE;
         press     <= 1'b0;
         press_key <= KEY_NONE;
      end else begin
         press <= 1'b0;
         if (key != cand) begin
            cand <= key;
            cnt  <= CW'(1);
         end else begin
            if (cnt != CW'(STABLE_CYCLES))
               cnt <= cnt + CW'(1);
            // Commit on the edge the count reaches the threshold.
            if (cnt >= CW'(STABLE_CYCLES - 1) && stable != cand) begin
               stable    <= cand;
               press     <= (cand != KEY_NONE);
               press_key <= cand;
            end
         end
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// Debounced hex keypad entry: accumulates nibbles, clears, and commits
// the value to a consumer over a valid/ready handshake.
module keypad_entry
   import keypad_entry_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 20
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [4:0]                   key_in,
   output logic [4*DIGITS-1:0]          entry,
   output logic [$clog2(DIGITS+1)-1:0]  count,
   output logic                         full,
   output logic                         key_evt,
   output logic [4*DIGITS-1:0]          out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         err
);

   localparam int W   = 4 * DIGITS;
   localparam int CNW = $clog2(DIGITS + 1);

   logic [4:0] stable;
   logic       press;
   logic [4:0] press_key;
   logic       act;

   key_debounce #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .key_in   (key_in),
      .stable   (stable),
      .press    (press),
      .press_key(press_key)
   );

   assign act = press && key_is_hex(stable);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry     <= '0;
         count     <= '0;
         full      <= 1'b0;
         key_evt   <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         key_evt <= 1'b0;
         err     <= 1'b0;
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (act) begin
            key_evt <= 1'b1;
            unique case (1'b1)
               key_is_digit(press_key): begin
                  if (full) begin
                     err <= 1'b1;
                  end else begin
                     entry <= {entry[W-5:0], key_to_nibble(press_key)};
                     count <= count + CNW'(1);
                     full  <= (count == CNW'(DIGITS - 1));
                  end
               end
               (press_key == KEY_F): begin
                  entry <= '0;
                  count <= '0;
                  full  <= 1'b0;
               end
               (press_key == KEY_E): begin
                  // An accept in this same cycle frees the output slot.
                  if (!out_valid || out_ready) begin
                     out_data  <= entry;
                     out_valid <= 1'b1;
                     entry     <= '0;
                     count     <= '0;
                     full      <= 1'b0;
                  end else begin
                     err <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
